// File: rtl/alu_seq_controller.sv
// -----------------------------------------------------------------------------
// alu_seq_controller
//
// Purpose:
//   Sequences a programmable-length run of operand pairs through an 8-op ALU.
//   Each vector walks LOAD -> EXEC -> HOLD:
//     - LOAD drives a, b and op.
//     - EXEC registers the ALU result and flags.
//     - HOLD presents them on a valid/ready handshake.
//   Ops are visited round-robin over the set bits of an op mask that is latched
//   at start. After the last accepted vector, DONE pulses for one cycle and the
//   FSM returns to IDLE.
//
// Optional feature (compile-time macro ALU_SAT_EN):
//   When defined, ADD and SUB (not CMP) saturate unsigned:
//     - an ADD carry forces res to all ones;
//     - a SUB borrow forces res to zero.
//   CF and OF still describe the raw, unsaturated arithmetic. ZF and GZ follow
//   the saturated res. When undefined, every op wraps mod 2^W.
//
// Parameters:
//   W       operand/result width (>= 4)
//   LEN     vectors per run (1 .. 65535)
//   A_INIT  first operand a of a run
//   B_INIT  first operand b of a run
//   A_STEP  increment of a per vector (mod 2^W)
//   B_STEP  increment of b per vector (mod 2^W)
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   start      in   starts a run; only looked at in IDLE
//   op_mask    in   [7:0] enabled ops, bit i = op i; latched at start
//   res_ready  in   consumer accepts the result
//   a, b       out  [W-1:0] current operands
//   op         out  [2:0] current op code
//   res        out  [W-1:0] registered result
//   CF         out  carry / borrow / shift-out flag
//   GZ         out  result is signed > 0
//   ZF         out  result == 0
//   OF         out  signed overflow (ADD/SUB/CMP only)
//   res_valid  out  res and flags are valid
//   busy       out  run in progress (LOAD, EXEC, HOLD, DONE)
//   done       out  one-cycle pulse when the run completes
//   dbg_state  out  [2:0] current FSM state, for checkers and debug
//
// Handshake (res_valid / res_ready):
//   A result transfers on every rising edge where res_valid && res_ready.
//   While res_valid is high and res_ready is low, the following are all held
//   stable: res, flags, a, b and op.
//   res_valid does not depend combinationally on res_ready. It falls in the
//   cycle after the accepting edge.
// -----------------------------------------------------------------------------
module alu_seq_controller #(
   parameter int W      = 7,
   parameter int LEN    = 16,
   parameter int A_INIT = 5,
   parameter int B_INIT = 3,
   parameter int A_STEP = 3,
   parameter int B_STEP = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [7:0]   op_mask,
   input  logic         res_ready,
   output logic [W-1:0] a,
   output logic [W-1:0] b,
   output logic [2:0]   op,
   output logic [W-1:0] res,
   output logic         CF,
   output logic         GZ,
   output logic         ZF,
   output logic         OF,
   output logic         res_valid,
   output logic         busy,
   output logic         done,
   output logic [2:0]   dbg_state
);

   // Op codes
   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_SHL = 3'd5;
   localparam logic [2:0] OP_SHR = 3'd6;
   localparam logic [2:0] OP_CMP = 3'd7;

   localparam logic [W-1:0] A0    = W'(A_INIT);
   localparam logic [W-1:0] B0    = W'(B_INIT);
   localparam logic [W-1:0] ASTEP = W'(A_STEP);
   localparam logic [W-1:0] BSTEP = W'(B_STEP);
   localparam logic [15:0]  LEN_C = 16'(LEN);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_EXEC = 3'd2,
      S_HOLD = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t      state;
   logic [15:0] count;
   logic [7:0]  mask_q;
   logic [7:0]  mask_eff;

   // ALU datapath (combinational from the a/b/op registers)
   logic [W:0]   sum_w;
   logic [W:0]   diff_w;
   logic [W-1:0] alu_res;
   logic         alu_cf;
   logic         alu_of;
   logic         alu_zf;
   logic         alu_gz;

   // Next enabled op strictly above cur, wrapping 7 -> 0.
   // If cur is the only set bit, the search wraps all the way round to cur.
   // Searching from cur = 7 therefore yields the lowest set bit, which is how
   // the first op of a run is chosen.
   function automatic logic [2:0] next_op(input logic [7:0] m, input logic [2:0] cur);
      logic [2:0] r;
      logic [2:0] idx;
      logic       found;
      r     = cur;
      found = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         idx = cur + 3'(k);
         if (!found && m[idx]) begin
            r     = idx;
            found = 1'b1;
         end
      end
      return r;
   endfunction

   // An all-zero mask would leave nothing to step through, so treat it as ADD-only.
   assign mask_eff  = (op_mask == 8'h00) ? 8'h01 : op_mask;
   assign dbg_state = state;

   always_comb begin
      sum_w   = {1'b0, a} + {1'b0, b};
      diff_w  = {1'b0, a} - {1'b0, b};
      alu_res = '0;
      alu_cf  = 1'b0;
      alu_of  = 1'b0;
      case (op)
         OP_ADD: begin
            alu_res = sum_w[W-1:0];
            alu_cf  = sum_w[W];
            // Overflow: operands share a sign that the result does not.
            alu_of  = (a[W-1] == b[W-1]) && (sum_w[W-1] != a[W-1]);
`ifdef ALU_SAT_EN
            if (sum_w[W]) alu_res = '1;
`endif
         end
         OP_SUB: begin
            alu_res = diff_w[W-1:0];
            alu_cf  = diff_w[W];   // borrow, i.e. a < b unsigned
            // Overflow: operand signs differ and the result sign differs from a.
            alu_of  = (a[W-1] != b[W-1]) && (diff_w[W-1] != a[W-1]);
`ifdef ALU_SAT_EN
            if (diff_w[W]) alu_res = '0;
`endif
         end
         OP_CMP: begin
            // Same arithmetic as SUB, but never saturated.
            alu_res = diff_w[W-1:0];
            alu_cf  = diff_w[W];
            alu_of  = (a[W-1] != b[W-1]) && (diff_w[W-1] != a[W-1]);
         end
         OP_AND: alu_res = a & b;
         OP_OR:  alu_res = a | b;
         OP_XOR: alu_res = a ^ b;
         OP_SHL: begin
            alu_res = {a[W-2:0], 1'b0};
            alu_cf  = a[W-1];
         end
         OP_SHR: begin
            alu_res = {1'b0, a[W-1:1]};
            alu_cf  = a[0];
         end
         default: begin
            alu_res = '0;
            alu_cf  = 1'b0;
            alu_of  = 1'b0;
         end
      endcase
      alu_zf = (alu_res == '0);
      alu_gz = (alu_res != '0) && !alu_res[W-1];
   end

   // Sequencing FSM. All outputs are registers owned by this single block.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         count     <= '0;
         mask_q    <= '0;
         a         <= '0;
         b         <= '0;
         op        <= '0;
         res       <= '0;
         CF        <= 1'b0;
         GZ        <= 1'b0;
         ZF        <= 1'b0;
         OF        <= 1'b0;
         res_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  a      <= A0;
                  b      <= B0;
                  count  <= '0;
                  mask_q <= mask_eff;
                  op     <= next_op(mask_eff, 3'd7);
                  busy   <= 1'b1;
                  state  <= S_LOAD;
               end
            end
            S_LOAD: begin
               state <= S_EXEC;
            end
            S_EXEC: begin
               res       <= alu_res;
               CF        <= alu_cf;
               GZ        <= alu_gz;
               ZF        <= alu_zf;
               OF        <= alu_of;
               res_valid <= 1'b1;
               state     <= S_HOLD;
            end
            S_HOLD: begin
               if (res_valid && res_ready) begin
                  res_valid <= 1'b0;
                  count     <= count + 16'd1;
                  if (count + 16'd1 == LEN_C) begin
                     // Operands stay at the last vector's values through DONE and IDLE.
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     a     <= a + ASTEP;
                     b     <= b + BSTEP;
                     op    <= next_op(mask_q, op);
                     state <= S_LOAD;
                  end
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq_controller.sv
// -----------------------------------------------------------------------------
// Testbench for alu_seq_controller.
//
// Four instances share clk/rst:
//   u0  default parameters (LEN=16)
//   u1  LEN=4
//   u2  A_INIT=100, B_INIT=60, LEN=1
//   u3  A_INIT=3,   B_INIT=5,  LEN=1
//
// Each has its own start/op_mask/res_ready.
// Expected vectors are queued in exp_q, either from hand-computed tables or
// from a small integer reference model. They are popped as each result
// appears in HOLD.
// -----------------------------------------------------------------------------
module tb_alu_seq_controller;

   localparam int W  = 7;
   localparam int EW = 28;   // {a[7], b[7], op[3], res[7], CF, GZ, ZF, OF}

   logic         clk;
   logic         rst;
   logic         start_i [4];
   logic [7:0]   mask_i  [4];
   logic         rdy_i   [4];
   logic [W-1:0] a_o     [4];
   logic [W-1:0] b_o     [4];
   logic [W-1:0] res_o   [4];
   logic [2:0]   op_o    [4];
   logic [2:0]   st_o    [4];
   logic         cf_o    [4];
   logic         gz_o    [4];
   logic         zf_o    [4];
   logic         of_o    [4];
   logic         rv_o    [4];
   logic         busy_o  [4];
   logic         done_o  [4];

   logic [EW-1:0] exp_q[$];
   int n_checks = 0;
   int n_errors = 0;

   // ---------------------------------------------------------------- DUTs
   alu_seq_controller u0 (
      .clk(clk), .rst(rst), .start(start_i[0]), .op_mask(mask_i[0]), .res_ready(rdy_i[0]),
      .a(a_o[0]), .b(b_o[0]), .op(op_o[0]), .res(res_o[0]),
      .CF(cf_o[0]), .GZ(gz_o[0]), .ZF(zf_o[0]), .OF(of_o[0]),
      .res_valid(rv_o[0]), .busy(busy_o[0]), .done(done_o[0]), .dbg_state(st_o[0]));

   alu_seq_controller #(.LEN(4)) u1 (
      .clk(clk), .rst(rst), .start(start_i[1]), .op_mask(mask_i[1]), .res_ready(rdy_i[1]),
      .a(a_o[1]), .b(b_o[1]), .op(op_o[1]), .res(res_o[1]),
      .CF(cf_o[1]), .GZ(gz_o[1]), .ZF(zf_o[1]), .OF(of_o[1]),
      .res_valid(rv_o[1]), .busy(busy_o[1]), .done(done_o[1]), .dbg_state(st_o[1]));

   alu_seq_controller #(.LEN(1), .A_INIT(100), .B_INIT(60)) u2 (
      .clk(clk), .rst(rst), .start(start_i[2]), .op_mask(mask_i[2]), .res_ready(rdy_i[2]),
      .a(a_o[2]), .b(b_o[2]), .op(op_o[2]), .res(res_o[2]),
      .CF(cf_o[2]), .GZ(gz_o[2]), .ZF(zf_o[2]), .OF(of_o[2]),
      .res_valid(rv_o[2]), .busy(busy_o[2]), .done(done_o[2]), .dbg_state(st_o[2]));

   alu_seq_controller #(.LEN(1), .A_INIT(3), .B_INIT(5)) u3 (
      .clk(clk), .rst(rst), .start(start_i[3]), .op_mask(mask_i[3]), .res_ready(rdy_i[3]),
      .a(a_o[3]), .b(b_o[3]), .op(op_o[3]), .res(res_o[3]),
      .CF(cf_o[3]), .GZ(gz_o[3]), .ZF(zf_o[3]), .OF(of_o[3]),
      .res_valid(rv_o[3]), .busy(busy_o[3]), .done(done_o[3]), .dbg_state(st_o[3]));

   // ---------------------------------------------------- clock / reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   // ------------------------------------------------------------- checking
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Every output of one instance packed together (7+7+3+7+4+3 = 31 bits).
   function automatic logic [31:0] outs_of(input int i);
      return {1'b0, a_o[i], b_o[i], op_o[i], res_o[i], cf_o[i], gz_o[i], zf_o[i], of_o[i],
              rv_o[i], busy_o[i], done_o[i]};
   endfunction

   // ------------------------------------------------------ reference model
   // Integer arithmetic on unsigned values, with a separate signed
   // interpretation used for overflow.
   function automatic logic [EW-1:0] model_vec(input int av, input int bv, input int opc);
      int   sa, sb, r, s;
      logic cf, ofl;
      sa  = (av >= 64) ? av - 128 : av;
      sb  = (bv >= 64) ? bv - 128 : bv;
      r   = 0;
      cf  = 1'b0;
      ofl = 1'b0;
      case (opc)
         0: begin
            r   = (av + bv) % 128;
            cf  = (av + bv) >= 128;
            s   = sa + sb;
            ofl = (s > 63) || (s < -64);
`ifdef ALU_SAT_EN
            if (cf) r = 127;
`endif
         end
         1, 7: begin
            r   = (av - bv + 128) % 128;
            cf  = av < bv;
            s   = sa - sb;
            ofl = (s > 63) || (s < -64);
`ifdef ALU_SAT_EN
            if (opc == 1 && cf) r = 0;
`endif
         end
         2: r = av & bv;
         3: r = av | bv;
         4: r = av ^ bv;
         5: begin
            r  = (av * 2) % 128;
            cf = av >= 64;
         end
         6: begin
            r  = av / 2;
            cf = (av % 2) == 1;
         end
         default: r = 0;
      endcase
      return {7'(av), 7'(bv), 3'(opc), 7'(r), cf, (r != 0 && r < 64), (r == 0), ofl};
   endfunction

   task automatic push_vec(input int av, input int bv, input int opc, input int rv,
                           input logic cf, input logic gz, input logic zf, input logic ofl);
      exp_q.push_back({7'(av), 7'(bv), 3'(opc), 7'(rv), cf, gz, zf, ofl});
   endtask

   // Queue a whole run from the model: operand stepping and round-robin op order.
   task automatic fill_model(input int ai, input int bi, input int as, input int bs,
                             input logic [7:0] m, input int nvec);
      logic [7:0] em;
      int av, bv, cur, nxt;
      logic found;
      em  = (m == 8'h00) ? 8'h01 : m;
      av  = ai;
      bv  = bi;
      cur = 0;
      found = 1'b0;
      for (int j = 0; j < 8; j++) begin
         if (!found && em[j]) begin
            cur   = j;
            found = 1'b1;
         end
      end
      for (int k = 0; k < nvec; k++) begin
         exp_q.push_back(model_vec(av, bv, cur));
         av = (av + as) % 128;
         bv = (bv + bs) % 128;
         found = 1'b0;
         nxt   = cur;
         for (int j = 1; j <= 8; j++) begin
            if (!found && em[(cur + j) % 8]) begin
               nxt   = (cur + j) % 8;
               found = 1'b1;
            end
         end
         cur = nxt;
      end
   endtask

   // ------------------------------------------------------------ driver
   // Call at a negedge with the instance idle.
   // stall = index of the vector held in HOLD for 5 cycles with res_ready low,
   // or -1 for none.
   task automatic run(input int idx, input logic [7:0] m, input int nvec, input int stall);
      int n;
      logic [EW-1:0] e;
      mask_i[idx]  = m;
      rdy_i[idx]   = 1'b1;
      start_i[idx] = 1'b1;
      @(posedge clk);
      #1 start_i[idx] = 1'b0;
      e = '0;
      for (int v = 0; v < nvec; v++) begin
         // From the start edge, and from every accepting edge, res_valid is
         // expected on the third negedge.
         n = 0;
         do begin
            @(negedge clk);
            n++;
            if (v == stall) rdy_i[idx] = 1'b0;
         end while (!rv_o[idx] && n < 10);
         e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
         check($sformatf("u%0d v%0d latency", idx, v), n, 3);
         check($sformatf("u%0d v%0d busy", idx, v), busy_o[idx], 1);
         check($sformatf("u%0d v%0d a", idx, v), a_o[idx], e[27:21]);
         check($sformatf("u%0d v%0d b", idx, v), b_o[idx], e[20:14]);
         check($sformatf("u%0d v%0d op", idx, v), op_o[idx], e[13:11]);
         check($sformatf("u%0d v%0d res", idx, v), res_o[idx], e[10:4]);
         check($sformatf("u%0d v%0d flags", idx, v),
               {cf_o[idx], gz_o[idx], zf_o[idx], of_o[idx]}, e[3:0]);
         if (v == stall) begin
            // Backpressure window. A start pulse inside it must be ignored.
            for (int k = 0; k < 5; k++) begin
               @(negedge clk);
               start_i[idx] = (k == 1);
               check($sformatf("u%0d stall%0d rv", idx, k), rv_o[idx], 1);
               check($sformatf("u%0d stall%0d hold", idx, k),
                     {a_o[idx], b_o[idx], op_o[idx], res_o[idx],
                      cf_o[idx], gz_o[idx], zf_o[idx], of_o[idx]}, e);
            end
            start_i[idx] = 1'b0;
            rdy_i[idx]   = 1'b1;
         end
      end
      // The last handshake lands on the next edge; DONE follows for one cycle.
      @(negedge clk);
      check($sformatf("u%0d done pulse", idx), {done_o[idx], rv_o[idx], busy_o[idx]}, 3'b101);
      @(negedge clk);
      check($sformatf("u%0d idle after done", idx), {done_o[idx], rv_o[idx], busy_o[idx]}, 3'b000);
      check($sformatf("u%0d last a/b/res held", idx),
            {a_o[idx], b_o[idx], res_o[idx]}, {e[27:21], e[20:14], e[10:4]});
   endtask

   // ------------------------------------------------------------ sequence
   initial begin
      int n;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         start_i[i] = 1'b0;
         mask_i[i]  = 8'h00;
         rdy_i[i]   = 1'b0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++) check($sformatf("u%0d reset outputs", i), outs_of(i), 0);
      rst = 1'b1;
      @(negedge clk);

      // LEN=4 ADD-only run: a 5,8,11,14 / b 3,8,13,18 / res 8,16,24,32
      push_vec(5, 3, 0, 8, 0, 1, 0, 0);
      push_vec(8, 8, 0, 16, 0, 1, 0, 0);
      push_vec(11, 13, 0, 24, 0, 1, 0, 0);
      push_vec(14, 18, 0, 32, 0, 1, 0, 0);
      run(1, 8'h01, 4, -1);

      // 100 + 60: carry out
`ifdef ALU_SAT_EN
      push_vec(100, 60, 0, 127, 1, 0, 0, 0);
`else
      push_vec(100, 60, 0, 32, 1, 1, 0, 0);
`endif
      run(2, 8'h01, 1, -1);

      // 3 - 5: borrow
`ifdef ALU_SAT_EN
      push_vec(3, 5, 1, 0, 1, 0, 1, 0);
`else
      push_vec(3, 5, 1, 126, 1, 0, 0, 0);
`endif
      run(3, 8'h02, 1, -1);

      // Mask A4: op order 2,5,7,2 (AND, SHL, CMP, AND)
      push_vec(5, 3, 2, 1, 0, 1, 0, 0);
      push_vec(8, 8, 5, 16, 0, 1, 0, 0);
      push_vec(11, 13, 7, 126, 1, 0, 0, 0);
      push_vec(14, 18, 2, 2, 0, 1, 0, 0);
      run(1, 8'hA4, 4, -1);

      // Mask 00 behaves as ADD-only
      push_vec(5, 3, 0, 8, 0, 1, 0, 0);
      push_vec(8, 8, 0, 16, 0, 1, 0, 0);
      push_vec(11, 13, 0, 24, 0, 1, 0, 0);
      push_vec(14, 18, 0, 32, 0, 1, 0, 0);
      run(1, 8'h00, 4, -1);

      // All eight ops twice over, with backpressure on vector 3
      fill_model(5, 3, 3, 5, 8'hFF, 16);
      run(0, 8'hFF, 16, 3);

      // Reset in the middle of a run (held in HOLD), then a clean restart
      mask_i[0]  = 8'h01;
      rdy_i[0]   = 1'b0;
      start_i[0] = 1'b1;
      @(posedge clk);
      #1 start_i[0] = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rv_o[0] && n < 10);
      check("u0 midrun rv before reset", rv_o[0], 1);
      rst = 1'b0;
      #1;
      check("u0 midrun reset outputs", outs_of(0), 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      fill_model(5, 3, 3, 5, 8'h01, 16);
      run(0, 8'h01, 16, -1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/alu_seq_controller.md
# alu_seq_controller

Parametrised successor to the 7-bit FSM ALU controller. It generates a programmable-length sequence of operand pairs, steps round-robin through a mask-selected set of eight ALU operations, and registers the result and flags. Each result is presented on a valid/ready handshake so a downstream checker or logger can apply backpressure. It sits between the stimulus/start logic and any result consumer in the FSM-ALU design.

## Interface
- W, 7: operand/result width (≥4).
- LEN, 16: vectors per run (1..2^16-1).
- A_INIT, 5: first operand a of a run.
- B_INIT, 3: first operand b of a run.
- A_STEP, 3: a increment per vector, mod 2^W.
- B_STEP, 5: b increment per vector, mod 2^W.

Ports (direction, width, meaning):
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  starts a run; sampled only in IDLE.
- op_mask  in  8  enabled ops; bit i = op i; sampled at start.
- res_ready  in  1  consumer accepts the result.
- a  out  W  current operand a.
- b  out  W  current operand b.
- op  out  3  current operation code.
- res  out  W  registered result.
- CF  out  1  carry/borrow/shift-out flag.
- GZ  out  1  result signed > 0.
- ZF  out  1  result == 0.
- OF  out  1  signed overflow.
- res_valid  out  1  res and flags valid.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse when the run completes.

## Operation
- Op codes:
  - 0 ADD a+b, 1 SUB a−b, 2 AND, 3 OR, 4 XOR.
  - 5 SHL a<<1, 6 SHR a>>1 (logical).
  - 7 CMP: res = a−b, same flags as SUB.
- CF:
  - ADD: carry out of bit W−1.
  - SUB/CMP: borrow (a<b unsigned).
  - SHL: a[W−1]. SHR: a[0].
  - Logic ops: 0.
- OF: signed overflow for ADD/SUB/CMP; 0 otherwise.
- ZF = (res==0). GZ = (res!=0 && res[W−1]==0).
- Op order:
  - First op of a run is the lowest set bit of the latched mask.
  - Each later op is the next set bit above the current one, wrapping 7→0.
  - A latched mask of 0 behaves as 8'h01 (ADD only).
- States:
  - IDLE: waits for start.
  - LOAD: a, b and op are driven.
  - EXEC: res and flags are registered.
  - HOLD: res_valid=1 until handshake.
  - DONE: done=1.
- Transitions:
  - IDLE→LOAD on start. The cycle that sees start latches a=A_INIT, b=B_INIT, count=0, mask and first op.
  - LOAD→EXEC→HOLD unconditionally.
  - HOLD on res_valid&&res_ready: count+1. If the new count == LEN, go to DONE. Otherwise a+=A_STEP, b+=B_STEP, op=next, then LOAD.
  - DONE→IDLE after one cycle. a, b, res and flags hold their last values.
- busy=1 in LOAD, EXEC, HOLD and DONE. start is ignored while busy.
- Operand and result arithmetic wraps mod 2^W unless saturation is compiled in (see Configuration).

## Timing
- rst low (any time, including mid-run): immediately sets state=IDLE and forces every output to 0 (a, b, op, res, CF, GZ, ZF, OF, res_valid, busy, done). The count and the latched mask also clear.
- start sampled high at edge t: LOAD at t+1, res_valid=1 from t+3.
- res, flags, a, b and op are stable while res_valid=1 && !res_ready.
- With res_ready held high: one vector every 3 cycles. The last handshake is followed by done=1 for exactly one cycle, then IDLE.
- Handshake is on the same edge: res_valid falls the cycle after acceptance.

## Configuration
- ALU_SAT_EN defined: ADD, and SUB only (not CMP), saturate unsigned.
  - ADD with carry gives res = all ones.
  - SUB with borrow gives res = 0.
  - CF still reports the raw carry/borrow. OF is computed on the unsaturated result. ZF/GZ use the saturated res.
- ALU_SAT_EN undefined: every op wraps mod 2^W.

## Test plan
All scenarios use default parameters unless stated.
- Reset mid-run: rst low during HOLD → all outputs 0 in the same cycle, busy=0. A new start after release restarts with a=5, b=3.
- LEN=4, op_mask=8'h01, res_ready=1, start at t → res_valid at t+3.
  - a = 5, 8, 11, 14; b = 3, 8, 13, 18; res = 8, 16, 24, 32; CF=0, GZ=1 for every vector.
  - done pulses once, 1 cycle after the 4th handshake.
- A_INIT=100, B_INIT=60, mask=8'h01 → res=32, CF=1, OF=0, GZ=1. With ALU_SAT_EN: res=127, CF=1.
- A_INIT=3, B_INIT=5, mask=8'h02 → res=126, CF=1, GZ=0, ZF=0. With ALU_SAT_EN: res=0, ZF=1, GZ=0.
- mask=8'hA4, LEN=4 → op sequence 2, 5, 7, 2. mask=8'h00 → every op = 0.
- res_ready=0 for 5 cycles in HOLD → res_valid stays 1 and a/b/op/res/flags are unchanged, count does not advance. A start pulse in this window has no effect.
